// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4 memory responder: FSM states, response codes,
// and the byte-lane offset used to turn byte addresses into word indices.
package axi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RREAD,
        ST_RDATA
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of byte-offset bits below the word index for a given data width.
    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port byte-enabled RAM with a registered (1-cycle) read port.
// The read register only updates on a pure read, so it holds the last read
// word while the port is idle or being written.
module iob_ram_sp_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   d_i,
    output logic [DATA_W-1:0]   d_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Byte-lane writes; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
            end
        end
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)                      d_o <= '0;
        else if (en_i && we_i == '0)    d_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory: one transaction at a time, INCR bursts only, alternating
// priority between AW and AR when both arrive together.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic [1:0]              s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic [1:0]              s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int LSB    = addr_lsb(AXI_DATA_W);
    localparam int STRB_W = AXI_DATA_W / 8;

    state_e                state_q, state_d;
    logic                  prio_w_q, prio_w_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [MEM_ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;

    logic                  sel_w;
    logic                  last_beat;
    logic                  ram_en;
    logic [STRB_W-1:0]     ram_we;

    // Burst type, size, cache etc. are accepted but have no effect.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                         s_axi_awprot, s_axi_awqos, s_axi_arsize, s_axi_arburst,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_awaddr, s_axi_araddr};

    assign last_beat   = (beat_q == len_q);
    // Write wins when alone, or when both are valid and it is the write's turn.
    assign sel_w       = s_axi_awvalid && (prio_w_q || !s_axi_arvalid);
    assign s_axi_bid   = id_q;
    assign s_axi_rid   = id_q;
    assign s_axi_rresp = RESP_OKAY;

    // Next-state, handshake outputs and RAM control.
    always_comb begin
        state_d       = state_q;
        prio_w_d      = prio_w_q;
        id_d          = id_q;
        idx_d         = idx_q;
        len_d         = len_q;
        beat_d        = beat_q;
        err_d         = err_q;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        ram_en        = 1'b0;
        ram_we        = '0;
        unique case (state_q)
            ST_IDLE: begin
                s_axi_awready = !rst && sel_w;
                s_axi_arready = !rst && !sel_w && s_axi_arvalid;
                if (s_axi_awready) begin
                    id_d     = s_axi_awid;
                    idx_d    = s_axi_awaddr[MEM_ADDR_W+LSB-1:LSB];
                    len_d    = s_axi_awlen;
                    beat_d   = '0;
                    err_d    = 1'b0;
                    prio_w_d = 1'b0;
                    state_d  = ST_WDATA;
                end else if (s_axi_arready) begin
                    id_d     = s_axi_arid;
                    idx_d    = s_axi_araddr[MEM_ADDR_W+LSB-1:LSB];
                    len_d    = s_axi_arlen;
                    beat_d   = '0;
                    prio_w_d = 1'b1;
                    state_d  = ST_RREAD;
                end
            end
            ST_WDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    ram_en = 1'b1;
                    ram_we = s_axi_wstrb;
                    if (s_axi_wlast != last_beat) err_d = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    beat_d = beat_q + 8'd1;
                    if (last_beat) state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (s_axi_bready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RREAD: begin
                ram_en  = 1'b1;
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = last_beat;
                if (s_axi_rready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        beat_d  = beat_q + 8'd1;
                        state_d = ST_RREAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Transaction context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_w_q <= 1'b1;
            id_q     <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            prio_w_q <= prio_w_d;
            id_q     <= id_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    iob_ram_sp_be #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (idx_q),
        .d_i    (s_axi_wdata),
        .d_o    (s_axi_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized self-checking bench for axi_mem_responder with a word-indexed
// memory model and directed timing, arbitration, error and reset scenarios.
module tb_axi_mem_responder;

    localparam int IDW    = 1;
    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int MAW    = 18;
    localparam int NWORDS = 1 << MAW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [IDW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [AW-1:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]     s_axi_awlen, s_axi_arlen;
    logic [2:0]     s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]     s_axi_awburst, s_axi_arburst, s_axi_awlock, s_axi_arlock;
    logic [3:0]     s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
    logic           s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [DW-1:0]  s_axi_wdata, s_axi_rdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic [1:0]     s_axi_bresp, s_axi_rresp;
    logic           s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic           s_axi_rlast, s_axi_rvalid, s_axi_rready;

    axi_mem_responder #(.AXI_ID_W(IDW), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .MEM_ADDR_W(MAW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] mem_m [int];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Word touched by beat b of a burst starting at byte address addr.
    function automatic int widx(input int addr, input int b);
        return ((addr / 4) + b) % NWORDS;
    endfunction

    task automatic do_aw(input int id, input int addr, input int len);
        bit hs = 1'b0;
        s_axi_awid = id[IDW-1:0]; s_axi_awaddr = addr[AW-1:0]; s_axi_awlen = len[7:0];
        s_axi_awvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = s_axi_awready;
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        chk("aw_accept", hs, 1);
    endtask

    task automatic do_ar(input int id, input int addr, input int len);
        bit hs = 1'b0;
        s_axi_arid = id[IDW-1:0]; s_axi_araddr = addr[AW-1:0]; s_axi_arlen = len[7:0];
        s_axi_arvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = s_axi_arready;
            @(posedge clk); #1;
        end
        s_axi_arvalid = 1'b0;
        chk("ar_accept", hs, 1);
    endtask

    // W beats from wd/ws, then B; bad>=0 puts wlast on that beat instead of the last.
    task automatic do_wb(input int id, input int addr, input int len, input int bad);
        for (int b = 0; b <= len; b++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast  = (bad >= 0) ? (b == bad) : (b == len);
            @(negedge clk);
            chk("wready", s_axi_wready, 1);
            begin
                int i = widx(addr, b);
                logic [31:0] w = mem_m.exists(i) ? mem_m[i] : 32'hx;
                for (int k = 0; k < 4; k++) if (ws[b][k]) w[k*8 +: 8] = wd[b][k*8 +: 8];
                mem_m[i] = w;
            end
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        @(negedge clk);
        chk("bvalid", s_axi_bvalid, 1);
        chk("bid", s_axi_bid, id);
        chk("bresp", s_axi_bresp, (bad >= 0) ? 2 : 0);
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    // R beats: one idle cycle then a valid beat each time; optional stall on one beat.
    task automatic do_r(input int id, input int addr, input int len, input int stall_beat, input int stall_cyc);
        for (int b = 0; b <= len; b++) begin
            int i = widx(addr, b);
            logic [31:0] exp = mem_m.exists(i) ? mem_m[i] : 32'hx;
            @(negedge clk); chk("r_gap", s_axi_rvalid, 0);
            @(negedge clk); chk("rvalid", s_axi_rvalid, 1);
            if (!$isunknown(exp)) chk("rdata", s_axi_rdata, exp);
            chk("rlast", s_axi_rlast, b == len);
            chk("rid", s_axi_rid, id);
            chk("rresp", s_axi_rresp, 0);
            if (b == stall_beat) begin
                repeat (stall_cyc) begin
                    @(negedge clk);
                    chk("rhold_v", s_axi_rvalid, 1);
                    if (!$isunknown(exp)) chk("rhold_d", s_axi_rdata, exp);
                    chk("rhold_l", s_axi_rlast, b == len);
                end
            end
            s_axi_rready = 1'b1;
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
        end
    endtask

    task automatic write_burst(input int id, input int addr, input int len);
        do_aw(id, addr, len);
        do_wb(id, addr, len, -1);
    endtask

    task automatic read_burst(input int id, input int addr, input int len, input int sb, input int sc);
        do_ar(id, addr, len);
        do_r(id, addr, len, sb, sc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        s_axi_awsize = 3'd2; s_axi_arsize = 3'd2; s_axi_awburst = 2'b01; s_axi_arburst = 2'b01;
        s_axi_awlock = '0; s_axi_arlock = '0; s_axi_awcache = '0; s_axi_arcache = '0;
        s_axi_awprot = '0; s_axi_arprot = '0; s_axi_awqos = '0; s_axi_arqos = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_wready",  s_axi_wready, 0);
        chk("rst_bvalid",  s_axi_bvalid, 0);
        chk("rst_rvalid",  s_axi_rvalid, 0);
        chk("rst_rlast",   s_axi_rlast, 0);
        chk("rst_bid",     s_axi_bid, 0);
        chk("rst_rid",     s_axi_rid, 0);
        chk("rst_rdata",   s_axi_rdata, 0);
        chk("rst_bresp",   s_axi_bresp, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat write/read with ID echo
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(1, 'h10, 0);
        read_burst(1, 'h10, 0, -1, 0);

        // Burst of four and address aliasing above the RAM size
        for (int b = 0; b < 4; b++) begin wd[b] = b + 1; ws[b] = 4'hF; end
        write_burst(0, 'h100, 3);
        read_burst(0, 'h100, 3, -1, 0);
        read_burst(1, 'h100 + (1 << 20), 3, -1, 0);

        // Byte-strobe merge
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        write_burst(0, 'h20, 0);
        wd[0] = 32'hAAAAAAAA; ws[0] = 4'b0010;
        write_burst(0, 'h20, 0);
        read_burst(0, 'h20, 0, -1, 0);
        chk("merge_model", mem_m[8], 32'h1122AA44);

        // Back-pressure in the middle of a read burst
        for (int b = 0; b < 6; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        write_burst(1, 'h200, 5);
        read_burst(1, 'h200, 5, 2, 5);

        // Index wrap at the top of the RAM
        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        write_burst(0, (NWORDS - 2) * 4, 3);
        read_burst(0, (NWORDS - 2) * 4, 3, -1, 0);

        // Arbitration: write first after reset, then read first
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        wd[0] = $urandom; ws[0] = 4'hF;
        s_axi_awid = '0; s_axi_awaddr = 'h300; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        s_axi_arid = 1'b1; s_axi_araddr = 'h10; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("arb1_awready", s_axi_awready, 1);
        chk("arb1_arready", s_axi_arready, 0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        do_wb(0, 'h300, 0, -1);
        s_axi_awid = '0; s_axi_awaddr = 'h304; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        s_axi_arid = '0; s_axi_araddr = 'h300; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("arb2_awready", s_axi_awready, 0);
        chk("arb2_arready", s_axi_arready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        do_r(0, 'h300, 0, -1, 0);

        // Early wlast gives SLVERR; the next write is clean again
        for (int b = 0; b < 3; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        do_aw(1, 'h400, 2);
        do_wb(1, 'h400, 2, 1);
        read_burst(1, 'h400, 2, -1, 0);
        wd[0] = $urandom; ws[0] = 4'hF;
        write_burst(0, 'h410, 0);

        // Reset in the middle of a read burst
        do_ar(0, 'h100, 3);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_rvalid_before", s_axi_rvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", s_axi_rvalid, 0);
        chk("midrst_rdata", s_axi_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        read_burst(0, 'h100, 3, -1, 0);

        // Randomized traffic in a fully initialised window of 32 words
        for (int b = 0; b < 32; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        write_burst(0, 0, 31);
        for (int t = 0; t < 40; t++) begin
            int len  = $urandom_range(7, 0);
            int addr = $urandom_range(24, 0) * 4;
            int id   = $urandom_range(1, 0);
            if ($urandom_range(1, 0) == 1) begin
                for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                write_burst(id, addr, len);
            end else begin
                read_burst(id, addr, len, $urandom_range(len, 0), $urandom_range(3, 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
